// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-facing signals for the hazard controller: ID/EX hazard
// inputs from the pipeline and the stall/flush/multiply controls back to it.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_is_mul;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mul_start;
  logic        busy;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_mul, ex_memread, ex_rt, ex_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, mul_start, busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_mul, ex_memread, ex_rt, ex_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, mul_start, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use bubble and multi-cycle multiply stall.
// Optional stall statistics counter enabled by macro HAZARD_STALL_COUNT_EN.
module hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MUL     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // The mul_start cycle is the first stall cycle, so MUL itself lasts MUL_CYCLES-1 cycles.
  localparam logic [7:0] MUL_CNT_LOAD = 8'(MUL_CYCLES - 32'd2);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       lu_s;
  logic       mul_go_s;
  logic       pc_en_s;
  logic       ifid_en_s;
  logic       ifid_flush_s;
  logic       idex_flush_s;
  logic       mul_start_s;
  logic       busy_s;

  // Load-use hazard detection against the load currently in EX.
  always_comb begin
    lu_s = 1'b0;
    if (hz.ex_memread && (hz.ex_rt != 5'd0) &&
        ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)))) begin
      lu_s = 1'b1;
    end else begin
      lu_s = 1'b0;
    end
  end

  assign mul_go_s = (state_r == RUN) && hz.id_is_mul && !hz.ex_branch_taken && !lu_s;

  // Multiply sequencing FSM and its down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (mul_go_s) begin
            state_r <= MUL;
            cnt_r   <= MUL_CNT_LOAD;
          end else begin
            state_r <= RUN;
          end
        end
        MUL: begin
          if (cnt_r == 8'd0) begin
            state_r <= RELEASE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RELEASE: state_r <= RUN;
        default: begin
          state_r <= RUN;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

  // Control outputs; branch and load-use act in the same cycle so these stay combinational.
  always_comb begin
    pc_en_s      = 1'b1;
    ifid_en_s    = 1'b1;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    mul_start_s  = 1'b0;
    busy_s       = 1'b0;
    if (!rst) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else begin
      case (state_r)
        RUN, RELEASE: begin
          busy_s = (state_r == RELEASE);
          if (hz.ex_branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (lu_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
          end else if (mul_go_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
            mul_start_s  = 1'b1;
            busy_s       = 1'b1;
          end else begin
            pc_en_s = 1'b1;
          end
        end
        MUL: begin
          // EX only holds bubbles here, so its load/branch indications are ignored.
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          idex_flush_s = 1'b1;
          busy_s       = 1'b1;
        end
        default: begin
          pc_en_s = 1'b1;
        end
      endcase
    end
  end

  assign hz.pc_en      = pc_en_s;
  assign hz.ifid_en    = ifid_en_s;
  assign hz.ifid_flush = ifid_flush_s;
  assign hz.idex_flush = idex_flush_s;
  assign hz.mul_start  = mul_start_s;
  assign hz.busy       = busy_s;

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of stalled (pc_en low) cycles outside reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if (!pc_en_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
`else
  assign hz.stall_cnt = 16'd0;
`endif

endmodule
